// File: rtl/mult_int_psum_accum.sv
// Purpose : sums cfg_len signed products from the bit-serial multiplier into one partial sum
//           and hands it to the PE output stage.
// Latency : prod_ack is combinational. psum_valid rises the cycle after the last product
//           transfers. There is one IDLE bubble cycle between consecutive sums.
// Backpressure: prod_ack is held low while a sum waits in DRAIN, which stalls the multiplier
//           until psum_ready is seen. en=0 freezes all state and holds prod_ack low.
// Ports   : clk/rst (sync, active-high), en, cfg_len/cfg_sat (sampled in IDLE), clear,
//           prod_valid/prod_data/prod_ack (multiplier side),
//           psum_valid/psum_ready/psum_data/psum_ovf (output side), busy.
// ACC_W must be >= MAX_WEI_PRECISION_INT + MAX_ACT_PRECISION_INT.
module mult_int_psum_accum #(
  parameter int MAX_WEI_PRECISION_INT = 16,
  parameter int MAX_ACT_PRECISION_INT = 16,
  parameter int ACC_W                 = 48,
  parameter int LEN_W                 = 16,
  localparam int PW = MAX_WEI_PRECISION_INT + MAX_ACT_PRECISION_INT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_sat,
  input  logic             clear,
  input  logic             prod_valid,
  input  logic [PW-1:0]    prod_data,
  output logic             prod_ack,
  output logic             psum_valid,
  input  logic             psum_ready,
  output logic [ACC_W-1:0] psum_data,
  output logic             psum_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             sat_q;
  logic             ovf;

  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] cnt_inc;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum_ext;
  logic             sum_ovf;
  logic [ACC_W-1:0] acc_nxt;

  // Gated by rst so the multiplier never sees an ack while the block is held in reset.
  assign prod_ack = en & ~rst & prod_valid & ((state == IDLE) | (state == ACCUM));

  assign len_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign cnt_inc  = cnt + LEN_W'(1);

  // The sum is formed one bit wider than the accumulator. Overflow shows up as
  // disagreement between the top two bits of that wider result.
  assign prod_ext = (ACC_W+1)'($signed(prod_data));
  assign sum_ext  = {acc[ACC_W-1], acc} + prod_ext;
  assign sum_ovf  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

  always_comb begin
    acc_nxt = sum_ext[ACC_W-1:0];
    if (sum_ovf && sat_q) begin
      // Bit ACC_W holds the true sign, so it selects which rail to clamp to.
      acc_nxt = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      len_q      <= LEN_W'(1);
      sat_q      <= 1'b0;
      psum_valid <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          len_q <= len_eff;
          sat_q <= cfg_sat;
          if (clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (prod_ack) begin
            // The first product always fits, because ACC_W >= PW.
            acc <= prod_ext[ACC_W-1:0];
            cnt <= LEN_W'(1);
            ovf <= 1'b0;
            if (len_eff == LEN_W'(1)) begin
              state      <= DRAIN;
              psum_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end

        ACCUM: begin
          // A product acked together with clear is dropped.
          if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end else if (prod_ack) begin
            acc <= acc_nxt;
            ovf <= ovf | sum_ovf;
            cnt <= cnt_inc;
            if (cnt_inc == len_q) begin
              state      <= DRAIN;
              psum_valid <= 1'b1;
            end
          end
        end

        DRAIN: begin
          // clear is ignored here. A finished sum always drains first.
          if (psum_ready) begin
            state      <= IDLE;
            psum_valid <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          psum_valid <= 1'b0;
        end
      endcase
    end
  end

  // acc is frozen in DRAIN, so it serves directly as the registered output data.
  assign psum_data = acc;
  assign psum_ovf  = ovf;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mult_int_psum_accum.sv
module tb_mult_int_psum_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] cfg_len;
  logic        cfg_sat;
  logic        clear;
  logic        prod_valid;
  logic [31:0] prod_data;
  logic        prod_ack;
  logic        psum_valid;
  logic        psum_ready;
  logic [47:0] psum_data;
  logic        psum_ovf;
  logic        busy;

  // A narrow twin that shares every input and reaches its overflow rails within a few products.
  logic        s_prod_ack;
  logic        s_psum_valid;
  logic [32:0] s_psum_data;
  logic        s_psum_ovf;
  logic        s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_int_psum_accum #(.ACC_W(48)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_len(cfg_len), .cfg_sat(cfg_sat), .clear(clear),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ack(prod_ack),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .psum_ovf(psum_ovf), .busy(busy)
  );

  mult_int_psum_accum #(.ACC_W(33)) u_small (
    .clk(clk), .rst(rst), .en(en), .cfg_len(cfg_len), .cfg_sat(cfg_sat), .clear(clear),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ack(s_prod_ack),
    .psum_valid(s_psum_valid), .psum_ready(psum_ready), .psum_data(s_psum_data),
    .psum_ovf(s_psum_ovf), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one product and expect it to be acked in this cycle.
  task automatic put(input string tag, input logic [31:0] d);
    prod_valid = 1'b1;
    prod_data  = d;
    #1;
    check(tag, prod_ack, 1);
    check({tag, "_s"}, s_prod_ack, 1);
    cyc();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cfg_len = 16'd4; cfg_sat = 1'b0; clear = 1'b0;
    prod_valid = 1'b1; prod_data = 32'd1; psum_ready = 1'b1;

    // Reset held for 2 cycles while a product is offered.
    cyc();
    check("rst_ack0", prod_ack, 0);
    cyc();
    check("rst_ack1", prod_ack, 0);
    check("rst_valid", psum_valid, 0);
    check("rst_data", psum_data, 0);
    check("rst_ovf", psum_ovf, 0);
    check("rst_busy", busy, 0);

    // Sum of 4: 3 - 5 + 7 + 10 = 15. The first ack comes the cycle rst falls.
    rst = 1'b0;
    put("len4_p0", 32'd3);
    check("len4_busy", busy, 1);
    check("len4_nv", psum_valid, 0);
    put("len4_p1", 32'hFFFF_FFFB);
    put("len4_p2", 32'd7);
    put("len4_p3", 32'd10);
    prod_data = 32'd20;
    #1;
    check("len4_valid", psum_valid, 1);
    check("len4_data", psum_data, 48'd15);
    check("len4_ovf", psum_ovf, 0);
    check("len4_stall", prod_ack, 0);
    cyc();
    check("len4_done", psum_valid, 0);

    // Backpressure: len 2, 20 + 22 = 42, psum_ready low for 5 cycles.
    cfg_len = 16'd2;
    put("bp_p0", 32'd20);
    psum_ready = 1'b0;
    put("bp_p1", 32'd22);
    prod_data = 32'd77;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", psum_valid, 1);
      check("bp_data", psum_data, 48'd42);
      check("bp_ack", prod_ack, 0);
      cyc();
    end
    psum_ready = 1'b1;
    #1;
    check("bp_release", psum_data, 48'd42);
    cyc();
    check("bp_idle", psum_valid, 0);

    // The stalled product 77 is still accepted. cfg_len=0 acts as 1.
    cfg_len = 16'd0;
    put("len0_p77", 32'd77);
    prod_valid = 1'b0;
    check("len0_v77", psum_valid, 1);
    check("len0_d77", psum_data, 48'd77);
    cyc();
    for (int i = 0; i < 2; i++) begin
      put("len0_p9", 32'd9);
      prod_valid = 1'b0;
      check("len0_v9", psum_valid, 1);
      check("len0_d9", psum_data, 48'd9);
      cyc();
    end

    // clear on the 2nd transfer of a len-3 sum. The next sum is 5 + 6 + 7 = 18.
    cfg_len = 16'd3;
    put("clr_p0", 32'd100);
    clear = 1'b1;
    put("clr_p1", 32'd200);
    clear = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_nv", psum_valid, 0);
    put("clr_q0", 32'd5);
    put("clr_q1", 32'd6);
    put("clr_q2", 32'd7);
    prod_valid = 1'b0;
    check("clr_valid", psum_valid, 1);
    check("clr_data", psum_data, 48'd18);
    cyc();

    // en low for 3 cycles at cnt=2 of 4. The expected sum is 1 + 2 + 3 + 4 = 10.
    cfg_len = 16'd4;
    put("en_p0", 32'd1);
    put("en_p1", 32'd2);
    en = 1'b0;
    prod_valid = 1'b1;
    prod_data = 32'd1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en_ack", prod_ack, 0);
      check("en_busy", busy, 1);
      cyc();
    end
    en = 1'b1;
    put("en_p2", 32'd3);
    put("en_p3", 32'd4);
    prod_valid = 1'b0;
    en = 1'b0;
    check("en_data", psum_data, 48'd10);
    cyc();
    // With en low, psum_ready is not taken.
    check("en_hold", psum_valid, 1);
    en = 1'b1;
    cyc();
    check("en_drained", psum_valid, 0);

    // A rst pulse in DRAIN drops the pending sum.
    cfg_len = 16'd1;
    put("rstd_p", 32'd50);
    prod_valid = 1'b0;
    psum_ready = 1'b0;
    check("rstd_valid", psum_valid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rstd_nv", psum_valid, 0);
    check("rstd_data", psum_data, 0);
    check("rstd_busy", busy, 0);
    psum_ready = 1'b1;
    cyc();

    // Overflow, saturating: 3 x (2^31-1). The narrow twin clamps to 2^32-1.
    cfg_len = 16'd3;
    cfg_sat = 1'b1;
    for (int i = 0; i < 3; i++) put("sat_p", 32'h7FFF_FFFF);
    prod_valid = 1'b0;
    check("sat_s_valid", s_psum_valid, 1);
    check("sat_s_data", s_psum_data, 33'h0_FFFF_FFFF);
    check("sat_s_ovf", s_psum_ovf, 1);
    check("sat_w_data", psum_data, 48'd6442450941);
    check("sat_w_ovf", psum_ovf, 0);
    cyc();

    // Same products with wrap. The narrow twin truncates to 0x1_7FFF_FFFD and flags ovf.
    cfg_sat = 1'b0;
    for (int i = 0; i < 3; i++) put("wrap_p", 32'h7FFF_FFFF);
    prod_valid = 1'b0;
    check("wrap_s_data", s_psum_data, 33'h1_7FFF_FFFD);
    check("wrap_s_ovf", s_psum_ovf, 1);
    check("wrap_w_ovf", psum_ovf, 0);
    cyc();

    // Negative saturation: 3 x (-2^31). The narrow twin clamps to -2^32.
    cfg_sat = 1'b1;
    for (int i = 0; i < 3; i++) put("nsat_p", 32'h8000_0000);
    prod_valid = 1'b0;
    check("nsat_s_data", s_psum_data, 33'h1_0000_0000);
    check("nsat_s_ovf", s_psum_ovf, 1);
    check("nsat_s_busy", s_busy, 1);
    check("nsat_w_data", psum_data, 48'hFFFE_8000_0000);
    cyc();
    check("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
